// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU core: opcodes, FSM states,
// instruction field positions and immediate sign extension.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_ADDI = 4'd6;
  localparam logic [3:0] OP_LD   = 4'd7;
  localparam logic [3:0] OP_ST   = 4'd8;
  localparam logic [3:0] OP_BEQ  = 4'd9;
  localparam logic [3:0] OP_JMP  = 4'd10;
  localparam logic [3:0] OP_HALT = 4'd11;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 28;
  localparam int RD_HI  = 27;
  localparam int RD_LO  = 23;
  localparam int RS1_HI = 22;
  localparam int RS1_LO = 18;
  localparam int RS2_HI = 17;
  localparam int RS2_LO = 13;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  function automatic logic [63:0] sext16(input logic [15:0] v);
    return {{48{v[15]}}, v};
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// Register file: r0 reads zero, indices >= NUM_REGS read zero and
// drop writes; two operand read ports plus a debug read port.
module cpu_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [4:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [4:0]        raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [4:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [4:0]        dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
);

  logic [DATA_W-1:0] regs_q [1:NUM_REGS-1];
  logic [DATA_W-1:0] regs_d [1:NUM_REGS-1];

  always_comb begin
    rdata_a   = '0;
    rdata_b   = '0;
    dbg_rdata = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (raddr_a == 5'(i)) rdata_a = regs_q[i];
      if (raddr_b == 5'(i)) rdata_b = regs_q[i];
      if (dbg_raddr == 5'(i)) dbg_rdata = regs_q[i];
    end
  end

  always_comb begin
    for (int i = 1; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (we && waddr == 5'(i)) regs_d[i] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 1; i < NUM_REGS; i++) begin
      if (!rst_n) regs_q[i] <= '0;
      else        regs_q[i] <= regs_d[i];
    end
  end

endmodule

// File: rtl/multicycle_cpu_core.sv
// Multicycle CPU core: FETCH/DECODE/EXEC/MEM/WB/HALT over handshaked
// memories. Performance counters built only with CPU_PERF_COUNTERS_EN.
module multicycle_cpu_core
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int PC_W     = 16,
  parameter int DADDR_W  = 16,
  parameter int NUM_REGS = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [31:0]        imem_rdata,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic               dmem_ready,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic [4:0]         dbg_raddr,
  output logic [DATA_W-1:0]  dbg_rdata,
  output logic [PC_W-1:0]    pc_o,
  output logic               retire,
  output logic               halted,
  output logic               illegal_op,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        retire_cnt
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [3:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [15:0]       imm_q, imm_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              ill_q, ill_d;

  logic [3:0]        ir_op;
  logic [4:0]        rf_raddr_b;
  logic [DATA_W-1:0] rf_rdata_a;
  logic [DATA_W-1:0] rf_rdata_b;
  logic [DATA_W-1:0] imm_dw;
  logic [PC_W-1:0]   imm_pw;
  logic              exec_retires;
  logic              mem_done;

  assign ir_op  = ir_q[OP_HI:OP_LO];
  assign imm_dw = DATA_W'(sext16(imm_q));
  assign imm_pw = PC_W'(sext16(imm_q));

  // Stores and branches read rd as their second operand.
  assign rf_raddr_b = (ir_op == OP_ST || ir_op == OP_BEQ)
                    ? ir_q[RD_HI:RD_LO] : ir_q[RS2_HI:RS2_LO];

  cpu_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (state_q == S_WB),
    .waddr     (rd_q),
    .wdata     (res_q),
    .raddr_a   (ir_q[RS1_HI:RS1_LO]),
    .rdata_a   (rf_rdata_a),
    .raddr_b   (rf_raddr_b),
    .rdata_b   (rf_rdata_b),
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata)
  );

  assign imem_req   = rst_n && state_q == S_FETCH;
  assign imem_addr  = pc_q;
  assign dmem_req   = rst_n && state_q == S_MEM;
  assign dmem_we    = op_q == OP_ST;
  assign dmem_addr  = res_q[DADDR_W-1:0];
  assign dmem_wdata = b_q;
  assign pc_o       = pc_q;
  assign halted     = state_q == S_HALT;
  assign illegal_op = ill_q;

  assign mem_done     = dmem_req && dmem_ready;
  assign exec_retires = !(op_q inside {[OP_ADD:OP_ST]});
  assign retire = (state_q == S_WB)
               || (mem_done && op_q == OP_ST)
               || (state_q == S_EXEC && exec_retires);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    op_d    = op_q;
    rd_d    = rd_q;
    imm_d   = imm_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    ill_d   = ill_q;
    case (state_q)
      S_FETCH: begin
        if (imem_valid) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        op_d    = ir_op;
        rd_d    = ir_q[RD_HI:RD_LO];
        imm_d   = ir_q[IMM_HI:IMM_LO];
        a_d     = rf_rdata_a;
        b_d     = rf_rdata_b;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op_q)
          OP_NOP: ;
          OP_ADD: begin res_d = a_q + b_q; state_d = S_WB; end
          OP_SUB: begin res_d = a_q - b_q; state_d = S_WB; end
          OP_AND: begin res_d = a_q & b_q; state_d = S_WB; end
          OP_OR:  begin res_d = a_q | b_q; state_d = S_WB; end
          OP_XOR: begin res_d = a_q ^ b_q; state_d = S_WB; end
          OP_ADDI: begin
            res_d   = a_q + imm_dw;
            state_d = S_WB;
          end
          OP_LD, OP_ST: begin
            res_d   = a_q + imm_dw;
            state_d = S_MEM;
          end
          OP_BEQ: if (b_q == a_q) pc_d = pc_q + imm_pw;
          OP_JMP:  pc_d = imm_pw;
          OP_HALT: state_d = S_HALT;
          default: ill_d = 1'b1;
        endcase
      end
      S_MEM: begin
        if (mem_done) begin
          if (op_q == OP_LD) begin
            res_d   = dmem_rdata;
            state_d = S_WB;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      op_q    <= OP_NOP;
      rd_q    <= '0;
      imm_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      imm_q   <= imm_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      ill_q   <= ill_d;
    end
  end

`ifdef CPU_PERF_COUNTERS_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;

  always_comb begin
    cycle_cnt_d  = cycle_cnt_q + {31'd0, state_q != S_HALT};
    retire_cnt_d = retire_cnt_q + {31'd0, retire};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      cycle_cnt_q  <= cycle_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign cycle_cnt  = cycle_cnt_q;
  assign retire_cnt = retire_cnt_q;
`else
  assign cycle_cnt  = '0;
  assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_cpu_core.sv
// Directed bench for multicycle_cpu_core with handshaked memory models
// that insert a configurable number of wait states.
module tb_multicycle_cpu_core;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;
  logic [15:0] pc_o;
  logic        retire;
  logic        halted;
  logic        illegal_op;
  logic [31:0] cycle_cnt;
  logic [31:0] retire_cnt;

  multicycle_cpu_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .dbg_raddr  (dbg_raddr),
    .dbg_rdata  (dbg_rdata),
    .pc_o       (pc_o),
    .retire     (retire),
    .halted     (halted),
    .illegal_op (illegal_op),
    .cycle_cnt  (cycle_cnt),
    .retire_cnt (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  int ilat = 0;
  int dlat = 0;
  int iwait = 0;
  int dwait = 0;

  assign imem_valid = imem_req && (iwait >= ilat);
  assign imem_rdata = imem[imem_addr[5:0]];
  assign dmem_ready = dmem_req && (dwait >= dlat);
  assign dmem_rdata = dmem[dmem_addr[5:0]];

  always @(posedge clk) begin
    if (!imem_req || imem_valid) iwait <= 0;
    else iwait <= iwait + 1;
  end

  always @(posedge clk) begin
    if (!dmem_req) begin
      dwait <= 0;
    end else if (dmem_ready) begin
      dwait <= 0;
      if (dmem_we) dmem[dmem_addr[5:0]] <= dmem_wdata;
    end else begin
      dwait <= dwait + 1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int ret_q[$];
  int fa_q[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic logic [31:0] enc_r(input logic [3:0] op,
    input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2, 13'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [3:0] op,
    input logic [4:0] rd, input logic [4:0] rs1, input logic [15:0] imm);
    return {op, rd, rs1, 2'b00, imm};
  endfunction

  task automatic sample();
    if (retire) ret_q.push_back(cyc);
    if (imem_req && imem_valid) fa_q.push_back(int'(imem_addr));
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      cyc++;
      sample();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    cyc = 1;
    ret_q.delete();
    fa_q.delete();
    sample();
  endtask

  task automatic clr_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'd0;
  endtask

  task automatic rd_dbg(input logic [4:0] r, output logic [31:0] v);
    dbg_raddr = r;
    #1;
    v = dbg_rdata;
  endtask

  logic [31:0] v;
  int nreq;

  initial begin
    rst_n = 1'b0;
    dbg_raddr = 5'd0;
    clr_imem();

    // ALU sequence, zero-wait fetch
    imem[0] = enc_i(4'd6, 5'd1, 5'd0, 16'd5);
    imem[1] = enc_i(4'd6, 5'd2, 5'd0, 16'd7);
    imem[2] = enc_r(4'd1, 5'd3, 5'd1, 5'd2);
    imem[3] = enc_i(4'd11, 5'd0, 5'd0, 16'd0);
    @(posedge clk);
    do_reset();
    chk("rst_pc", 64'(pc_o), 64'd0);
    chk("rst_imem_req", 64'(imem_req), 64'd1);
    chk("rst_dmem_req", 64'(dmem_req), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_illegal", 64'(illegal_op), 64'd0);
    chk("rst_retire_cnt", 64'(retire_cnt), 64'd0);
    run(11);
    chk("alu_nret", 64'(ret_q.size()), 64'd3);
    chk("alu_ret0", 64'(qget(ret_q, 0)), 64'd4);
    chk("alu_ret1", 64'(qget(ret_q, 1)), 64'd8);
    chk("alu_ret2", 64'(qget(ret_q, 2)), 64'd12);
    run(1);
    rd_dbg(5'd3, v);
    chk("alu_r3", 64'(v), 64'd12);
    run(3);
    chk("halt_ret", 64'(qget(ret_q, 3)), 64'd15);
    chk("halted", 64'(halted), 64'd1);
    nreq = 0;
    repeat (20) begin
      run(1);
      if (imem_req) nreq++;
    end
    chk("halt_no_req", 64'(nreq), 64'd0);
    chk("halt_still", 64'(halted), 64'd1);
`ifdef CPU_PERF_COUNTERS_EN
    chk("perf_retire", 64'(retire_cnt), 64'd4);
    chk("perf_cycle", 64'(cycle_cnt), 64'd15);
`else
    chk("perf_retire_off", 64'(retire_cnt), 64'd0);
    chk("perf_cycle_off", 64'(cycle_cnt), 64'd0);
`endif

    // store then load with 3 data wait cycles
    clr_imem();
    imem[0] = enc_i(4'd6, 5'd1, 5'd0, 16'h0020);
    imem[1] = enc_i(4'd8, 5'd1, 5'd0, 16'h0010);
    imem[2] = enc_i(4'd7, 5'd4, 5'd0, 16'h0010);
    imem[3] = enc_i(4'd11, 5'd0, 5'd0, 16'd0);
    dlat = 3;
    do_reset();
    rd_dbg(5'd3, v);
    chk("rst_clears_r3", 64'(v), 64'd0);
    run(8);
    chk("st_req", 64'(dmem_req), 64'd1);
    chk("st_we", 64'(dmem_we), 64'd1);
    chk("st_addr", 64'(dmem_addr), 64'h10);
    chk("st_wdata", 64'(dmem_wdata), 64'h20);
    run(7);
    chk("ld_wait_req", 64'(dmem_req), 64'd1);
    chk("ld_wait_we", 64'(dmem_we), 64'd0);
    chk("ld_wait_addr", 64'(dmem_addr), 64'h10);
    chk("ld_wait_retire", 64'(retire), 64'd0);
    run(3);
    chk("mem_nret", 64'(ret_q.size()), 64'd3);
    chk("st_ret", 64'(qget(ret_q, 1)), 64'd11);
    chk("ld_ret", 64'(qget(ret_q, 2)), 64'd19);
    run(1);
    rd_dbg(5'd4, v);
    chk("ld_r4", 64'(v), 64'h20);
    chk("st_mem", 64'(dmem[16]), 64'h20);

    // reset during the load's memory wait
    do_reset();
    run(15);
    chk("pre_rst_dreq", 64'(dmem_req), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_gate_dreq", 64'(dmem_req), 64'd0);
    chk("rst_gate_ireq", 64'(imem_req), 64'd0);
    do_reset();
    chk("mid_rst_pc", 64'(pc_o), 64'd0);
    chk("mid_rst_dreq", 64'(dmem_req), 64'd0);
    chk("mid_rst_ireq", 64'(imem_req), 64'd1);
    rd_dbg(5'd1, v);
    chk("mid_rst_r1", 64'(v), 64'd0);
    run(3);
    chk("resume_ret", 64'(qget(ret_q, 0)), 64'd4);
    dlat = 0;

    // branches and jump with one fetch wait cycle
    clr_imem();
    imem[0]  = enc_i(4'd6, 5'd1, 5'd0, 16'd1);
    imem[1]  = enc_i(4'd10, 5'd0, 5'd0, 16'd5);
    imem[5]  = enc_i(4'd9, 5'd0, 5'd0, 16'hFFFE);
    imem[4]  = enc_i(4'd10, 5'd0, 5'd0, 16'd10);
    imem[10] = enc_i(4'd9, 5'd1, 5'd0, 16'd3);
    imem[11] = enc_i(4'd11, 5'd0, 5'd0, 16'd0);
    ilat = 1;
    do_reset();
    run(60);
    chk("br_nfetch", 64'(fa_q.size()), 64'd6);
    chk("br_f0", 64'(qget(fa_q, 0)), 64'd0);
    chk("br_f1", 64'(qget(fa_q, 1)), 64'd1);
    chk("jmp_tgt", 64'(qget(fa_q, 2)), 64'd5);
    chk("beq_taken", 64'(qget(fa_q, 3)), 64'd4);
    chk("jmp_tgt2", 64'(qget(fa_q, 4)), 64'd10);
    chk("beq_not_taken", 64'(qget(fa_q, 5)), 64'd11);
    chk("br_halted", 64'(halted), 64'd1);
    ilat = 0;

    // r0 write ignored, illegal opcode sticky
    clr_imem();
    imem[0] = enc_i(4'd6, 5'd0, 5'd0, 16'd9);
    imem[1] = 32'hC000_0000;
    imem[2] = enc_i(4'd6, 5'd2, 5'd0, 16'd3);
    imem[3] = enc_i(4'd11, 5'd0, 5'd0, 16'd0);
    do_reset();
    run(6);
    chk("ill_before", 64'(illegal_op), 64'd0);
    chk("ill_exec_retire", 64'(retire), 64'd1);
    run(1);
    chk("ill_set", 64'(illegal_op), 64'd1);
    run(20);
    chk("ill_sticky", 64'(illegal_op), 64'd1);
    rd_dbg(5'd0, v);
    chk("r0_zero", 64'(v), 64'd0);
    rd_dbg(5'd2, v);
    chk("ill_r2", 64'(v), 64'd3);
    chk("ill_pc", 64'(pc_o), 64'd4);
    chk("ill_halted", 64'(halted), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
